// File: rtl/dpram_pkg.sv
// Shared constants, FSM state type and lane helpers for the byte-enable dual-port RAM.
// lane_merge handles words up to MERGE_W bits with lanes of at least 8 bits.
package dpram_pkg;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

  localparam int MERGE_W  = 64;
  localparam int MERGE_NB = 8;
  localparam int MERGE_IW = $clog2(MERGE_NB);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic int nbytes(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  // Lanes with be set come from new_word, the rest keep old_word.
  function automatic logic [MERGE_W-1:0] lane_merge(
    input logic [MERGE_W-1:0]  old_word,
    input logic [MERGE_W-1:0]  new_word,
    input logic [MERGE_NB-1:0] be,
    input int                  lane_w
  );
    logic [MERGE_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_W; i++) begin
      if (be[MERGE_IW'(i / lane_w)]) res[i] = new_word[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_port_pipe.sv
// Read-data / valid pipeline for one RAM port: one register stage, or two when OUTREG=1.
// Data registers only load on a valid read so q holds between accesses.
module dpram_port_pipe #(
  parameter int DATAWIDTH = 16,
  parameter int OUTREG    = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic [DATAWIDTH-1:0] q,
  output logic                 q_valid
);

  logic                 s1_valid_reg;
  logic [DATAWIDTH-1:0] s1_data_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
    end else begin
      s1_valid_reg <= in_valid;
      if (in_valid) s1_data_reg <= in_data;
    end
  end

  generate
    if (OUTREG != 0) begin : g_outreg
      logic                 s2_valid_reg;
      logic [DATAWIDTH-1:0] s2_data_reg;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          s2_valid_reg <= 1'b0;
          s2_data_reg  <= '0;
        end else begin
          s2_valid_reg <= s1_valid_reg;
          if (s1_valid_reg) s2_data_reg <= s1_data_reg;
        end
      end

      assign q       = s2_data_reg;
      assign q_valid = s2_valid_reg;
    end else begin : g_direct
      assign q       = s1_data_reg;
      assign q_valid = s1_valid_reg;
    end
  endgenerate

endmodule

// File: rtl/dpram_be_init.sv
// True dual-port RAM with byte enables, read-during-write select and a hardware clear sweep.
// Define DPRAM_COLLISION_EN to add the collision pulse and saturating collision_cnt outputs.
module dpram_be_init
  import dpram_pkg::*;
#(
  parameter int                   ADDRWIDTH     = 8,
  parameter int                   DATAWIDTH     = 16,
  parameter int                   BYTEWIDTH     = 8,
  parameter int                   OUTREG        = 0,
  parameter int                   RDW_MODE      = RDW_WRITE_FIRST,
  parameter logic [DATAWIDTH-1:0] INIT_VALUE    = '0,
  parameter int                   INIT_ON_RESET = 1
) (
  input  logic                                      clock,
  input  logic                                      reset_n,
  input  logic                                      init_req,
  output logic                                      init_busy,
  input  logic                                      en_a,
  input  logic                                      wren_a,
  input  logic [nbytes(DATAWIDTH, BYTEWIDTH)-1:0]   byteena_a,
  input  logic [ADDRWIDTH-1:0]                      address_a,
  input  logic [DATAWIDTH-1:0]                      data_a,
  output logic [DATAWIDTH-1:0]                      q_a,
  output logic                                      q_valid_a,
  input  logic                                      en_b,
  input  logic                                      wren_b,
  input  logic [nbytes(DATAWIDTH, BYTEWIDTH)-1:0]   byteena_b,
  input  logic [ADDRWIDTH-1:0]                      address_b,
  input  logic [DATAWIDTH-1:0]                      data_b,
  output logic [DATAWIDTH-1:0]                      q_b,
`ifdef DPRAM_COLLISION_EN
  output logic                                      q_valid_b,
  output logic                                      collision,
  output logic [15:0]                               collision_cnt
`else
  output logic                                      q_valid_b
`endif
);

  localparam int NBYTES = nbytes(DATAWIDTH, BYTEWIDTH);
  localparam int DEPTH  = 2**ADDRWIDTH;

  logic [DATAWIDTH-1:0] mem [DEPTH];

  state_t               state_reg, state_next;
  logic [ADDRWIDTH-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= (INIT_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (init_req) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_next = cnt_reg + ADDRWIDTH'(1);
        if (&cnt_reg) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign init_busy = (state_reg == ST_CLEAR);

  logic                 acc_a, acc_b;
  logic                 wr_a, wr_b;
  logic [DATAWIDTH-1:0] old_a, old_b;
  logic [DATAWIDTH-1:0] merged_a, merged_b;
  logic [DATAWIDTH-1:0] rd_a, rd_b;

  assign acc_a = en_a & ~init_busy;
  assign acc_b = en_b & ~init_busy;
  assign wr_a  = acc_a & wren_a & (|byteena_a);
  assign wr_b  = acc_b & wren_b & (|byteena_b);

  // Unregistered array reads are the pre-write word; cross-port reads always see this.
  assign old_a = mem[address_a];
  assign old_b = mem[address_b];

  assign merged_a = DATAWIDTH'(lane_merge(MERGE_W'(old_a), MERGE_W'(data_a),
                                          MERGE_NB'(byteena_a), BYTEWIDTH));
  assign merged_b = DATAWIDTH'(lane_merge(MERGE_W'(old_b), MERGE_W'(data_b),
                                          MERGE_NB'(byteena_b), BYTEWIDTH));

  assign rd_a = (RDW_MODE == RDW_WRITE_FIRST && wr_a) ? merged_a : old_a;
  assign rd_b = (RDW_MODE == RDW_WRITE_FIRST && wr_b) ? merged_b : old_b;

  // Port B lane writes come last, so B wins any lane both ports write.
  always_ff @(posedge clock) begin
    if (init_busy) begin
      mem[cnt_reg] <= INIT_VALUE;
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_a && byteena_a[i])
          mem[address_a][i*BYTEWIDTH +: BYTEWIDTH] <= data_a[i*BYTEWIDTH +: BYTEWIDTH];
        if (wr_b && byteena_b[i])
          mem[address_b][i*BYTEWIDTH +: BYTEWIDTH] <= data_b[i*BYTEWIDTH +: BYTEWIDTH];
      end
    end
  end

  dpram_port_pipe #(
    .DATAWIDTH (DATAWIDTH),
    .OUTREG    (OUTREG)
  ) u_pipe_a (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (acc_a),
    .in_data  (rd_a),
    .q        (q_a),
    .q_valid  (q_valid_a)
  );

  dpram_port_pipe #(
    .DATAWIDTH (DATAWIDTH),
    .OUTREG    (OUTREG)
  ) u_pipe_b (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (acc_b),
    .in_data  (rd_b),
    .q        (q_b),
    .q_valid  (q_valid_b)
  );

`ifdef DPRAM_COLLISION_EN
  logic        col_hit;
  logic        col_pre;
  logic        collision_reg;
  logic [15:0] collision_cnt_reg;

  assign col_hit = wr_a & wr_b & (address_a == address_b) & (|(byteena_a & byteena_b));

  generate
    if (OUTREG != 0) begin : g_col_outreg
      logic col_s1_reg;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) col_s1_reg <= 1'b0;
        else          col_s1_reg <= col_hit;
      end
      assign col_pre = col_s1_reg;
    end else begin : g_col_direct
      assign col_pre = col_hit;
    end
  endgenerate

  // Counter steps on the same edge the pulse rises, so both stay aligned with q_valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      collision_reg     <= 1'b0;
      collision_cnt_reg <= '0;
    end else begin
      collision_reg <= col_pre;
      if (col_pre && !(&collision_cnt_reg))
        collision_cnt_reg <= collision_cnt_reg + 16'd1;
    end
  end

  assign collision     = collision_reg;
  assign collision_cnt = collision_cnt_reg;
`endif

endmodule

// File: doc/dpram_be_init.md
Name: dpram_be_init

Overview:
Single-clock true dual-port block RAM, parametrised in width, depth and byte-lane granularity. Adds over the plain dual-port RAM:
- per-byte write enables
- selectable read-during-write mode
- optional output register stage
- read-valid strobes
- hardware clear sequencer that sweeps memory to INIT_VALUE after reset or on request
Used for NeoGeo palette/sprite line buffers that must start from a known state without a MIF.

Parameters:
ADDRWIDTH, 8, address bits; depth = 2**ADDRWIDTH.
DATAWIDTH, 16, word width; must be a multiple of BYTEWIDTH.
BYTEWIDTH, 8, lane width; NBYTES = DATAWIDTH/BYTEWIDTH.
OUTREG, 0, 0: read latency 1; 1: extra output register, latency 2.
RDW_MODE, 0, same-port read-during-write: 0 = write-first (new data), 1 = read-first (old data).
INIT_VALUE, 0, DATAWIDTH-bit word written by the clear sweep.
INIT_ON_RESET, 1, 1: sweep starts automatically on reset release.

Ports:
clock  in  1  single clock for both ports
reset_n  in  1  asynchronous active-low reset
init_req  in  1  pulse: start clear sweep (ignored while init_busy)
init_busy  out  1  high while sweep runs; port accesses are ignored
en_a  in  1  port A access strobe
wren_a  in  1  port A write (qualified by en_a)
byteena_a  in  NBYTES  port A lane enables
address_a  in  ADDRWIDTH  port A address
data_a  in  DATAWIDTH  port A write data
q_a  out  DATAWIDTH  port A read data
q_valid_a  out  1  port A read data valid pulse
en_b, wren_b, byteena_b, address_b, data_b, q_b, q_valid_b: same as port A, for port B.

Behaviour:
- Reset (async, reset_n=0):
  - q_a, q_b, q_valid_a, q_valid_b = 0.
  - FSM goes to CLEAR with counter 0 when INIT_ON_RESET=1 (init_busy=1); otherwise IDLE (init_busy=0).
  - Memory contents are not reset.
- FSM states and transitions:
  - IDLE -> CLEAR on init_req.
  - CLEAR writes INIT_VALUE, all lanes, to address cnt, one word per cycle; cnt increments.
  - CLEAR -> IDLE after writing address 2**ADDRWIDTH-1. The sweep takes exactly 2**ADDRWIDTH cycles; init_busy falls the cycle after the last write.
  - A reset assertion mid-sweep restarts at address 0 (INIT_ON_RESET=1) or aborts to IDLE (INIT_ON_RESET=0).
  - init_req in CLEAR is ignored; no restart.
- While init_busy=1: en_a/en_b are ignored, no writes occur, q_valid stays 0, q holds its value.
- Access issued in cycle N (en_x=1, init_busy=0):
  - q_x and q_valid_x update at the N+1 clock edge (OUTREG=0) or the N+2 edge (OUTREG=1).
  - q_valid_x is a 1-cycle pulse per access, back-to-back allowed (full throughput).
- Write (wren_x=1): only lanes with byteena_x[i]=1 are updated.
  - RDW_MODE=0: q_x = merged word (new enabled lanes, old disabled lanes).
  - RDW_MODE=1: q_x = pre-write word.
  - byteena=0 with wren=1 is a read.
- Cross-port, same address, same cycle:
  - A read on one port while the other port writes returns the old word, regardless of RDW_MODE.
  - Both ports writing overlapping lanes: port B wins per lane. Non-overlapping lanes merge.
- q_x holds its last value between accesses.
- Address wrap is natural ADDRWIDTH modulo. No out-of-range case exists.

Optional Feature:
Macro DPRAM_COLLISION_EN.
- Defined: adds output collision (1 bit), pulsing with the same latency as q_valid when both ports write any common lane at the same address. Adds output collision_cnt (16 bits), a saturating count cleared by reset_n.
- Undefined: neither port exists; port-B-wins resolution is unchanged.

Decomposition:
- Package dpram_pkg holds:
  - RDW_WRITE_FIRST=0 and RDW_READ_FIRST=1 constants
  - FSM state enum (ST_IDLE, ST_CLEAR)
  - function nbytes(DATAWIDTH, BYTEWIDTH)
  - function lane_merge(old, new, be)
- Sub-module dpram_port_pipe: OUTREG-selectable data/valid pipeline with async reset, instantiated once per port.

Test Plan:
- ADDRWIDTH=4, INIT_ON_RESET=1, INIT_VALUE=16'hA5A5: release reset -> init_busy high exactly 16 cycles; read all 16 addresses -> every q=16'hA5A5, q_valid 1 cycle after en.
- Port A writes 16'h1234 be=2'b11 to addr 3, then 16'hFF00 be=2'b10 -> read addr 3 gives 16'hFF34. With RDW_MODE=0 the second write's q_a=16'hFF34; with RDW_MODE=1 it is 16'h1234.
- Same cycle: A writes 16'h1111 be=2'b11, B writes 16'h2222 be=2'b01 to addr 7 -> read gives 16'h1122. Collision pulses once with DPRAM_COLLISION_EN.
- Same cycle: A writes 16'hBEEF to addr 5 (old 16'h0000) while B reads addr 5 -> q_b=16'h0000; next B read gives 16'hBEEF.
- OUTREG=1: reads on consecutive cycles to addrs 0,1,2 -> three consecutive q_valid pulses starting 2 cycles after the first en.
- init_req mid-traffic, then reset_n asserted after 5 sweep cycles -> outputs zero immediately; sweep restarts from 0 and lasts 16 cycles; writes during busy are dropped.
